// File: rtl/bus_synchronizer_if.sv
// Bus bundle between an asynchronous source and the bus_synchronizer receiver.
// The source drives tx_data/EN; the receiver returns rx_data/rx_valid in the
// destination clock domain.
interface bus_synchronizer_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 EN;
    logic [BUS_WIDTH-1:0] rx_data;
    logic                 rx_valid;

    // Source side: drives the quasi-static bus and its qualifying level.
    modport master (
        output tx_data,
        output EN,
        input  rx_data,
        input  rx_valid
    );

    // Receiver side: samples the bus on a synchronized EN rising edge.
    modport slave (
        input  tx_data,
        input  EN,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/bus_synchronizer.sv
// Enable-based multi-bit CDC receiver. EN passes through a flop chain; its
// rising edge in the destination domain loads the quasi-static tx_data into
// rx_data and raises rx_valid for one cycle. tx_data itself never goes through
// synchronizer flops: the source keeps it stable until the load has happened.
module bus_synchronizer #(
    parameter int BUS_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_synchronizer_if.slave bus
);

    // Configuration guards: reject unsupported sizes at elaboration.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("bus_synchronizer: SYNC_STAGES must be in 2..4");
        end
        if (BUS_WIDTH < 1 || BUS_WIDTH > 256) begin : g_bad_bus_width
            $error("bus_synchronizer: BUS_WIDTH must be in 1..256");
        end
    endgenerate

    // sync_q[0] is the first (metastability-catching) stage; the top bit is en_sync.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   en_sync;
    logic                   en_prev_q;
    logic                   load;

    logic [BUS_WIDTH-1:0]   rx_data_q;
    logic [BUS_WIDTH-1:0]   rx_data_d;
    logic                   rx_valid_q;
    logic                   rx_valid_d;

    // Shift EN into the chain; every later stage copies its predecessor.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.EN};
    end

    // Synchronizer chain register, cleared so a high EN at reset release reads as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign en_sync = sync_q[SYNC_STAGES-1];

    // Edge-detect history: previous cycle's synchronized enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_prev_q <= 1'b0;
        end else begin
            en_prev_q <= en_sync;
        end
    end

    // A load happens only on the cycle the synchronized enable first reads high.
    assign load = en_sync & ~en_prev_q;

    // Next-state for the capture register: hold data, pulse valid only on load.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (load) begin
            rx_data_d  = bus.tx_data;
            rx_valid_d = 1'b1;
        end
    end

    // Capture register: outputs come only from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_bus_synchronizer.sv
// Bench for bus_synchronizer: two instances (2- and 3-stage chains) share one
// stimulus stream; a reference model queues expected captures and a monitor
// compares every destination cycle.
module tb_bus_synchronizer;

    localparam int W = 8;

    typedef struct packed {
        int         due;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] tx;
    logic         en;

    always #5 clk = ~clk;

    bus_synchronizer_if #(.BUS_WIDTH(W)) if2 ();
    bus_synchronizer_if #(.BUS_WIDTH(W)) if3 ();

    assign if2.tx_data = tx;
    assign if2.EN      = en;
    assign if3.tx_data = tx;
    assign if3.EN      = en;

    bus_synchronizer #(.BUS_WIDTH(W), .SYNC_STAGES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    bus_synchronizer #(.BUS_WIDTH(W), .SYNC_STAGES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    // Scoreboard state: index 0 -> 2-stage instance, index 1 -> 3-stage instance.
    exp_t         q [2][$];
    logic [W-1:0] last [2];
    int           edge_cnt = 0;
    logic         en_seen  = 1'b0;
    int           nvec     = 0;
    int           nbad     = 0;

    // Reference model: each rising edge of EN as seen by clk sampling
    // produces one capture, SYNC_STAGES edges later, of the (stable) bus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                en_seen = 1'b0;
            end else begin
                if (en && !en_seen) begin
                    e.data = tx;
                    e.due  = edge_cnt + 2;
                    q[0].push_back(e);
                    e.due  = edge_cnt + 3;
                    q[1].push_back(e);
                end
                en_seen = en;
            end
            edge_cnt++;
        end
    end

    task automatic check(input int k, input logic v, input logic [W-1:0] d);
        int   cur;
        exp_t e;
        cur = edge_cnt - 1;
        nvec++;
        if (!rst_n) begin
            last[k] = '0;
            if (v !== 1'b0 || d !== '0) begin
                nbad++;
                $display("FAIL reset_outputs dut%0d: rx_valid=%b rx_data=%h, required 0/00", k, v, d);
            end
            return;
        end
        while (q[k].size() > 0 && q[k][0].due < cur) begin
            nbad++;
            e = q[k].pop_front();
            $display("FAIL missed_capture dut%0d: no rx_valid at edge %0d for data %h", k, e.due, e.data);
        end
        if (v === 1'b1) begin
            if (q[k].size() == 0 || q[k][0].due != cur) begin
                nbad++;
                $display("FAIL unexpected_valid dut%0d: rx_valid=1 rx_data=%h at edge %0d, required rx_valid=0", k, d, cur);
                last[k] = d;
            end else begin
                e = q[k].pop_front();
                last[k] = e.data;
                if (d !== e.data) begin
                    nbad++;
                    $display("FAIL capture_data dut%0d: rx_data=%h, required %h", k, d, e.data);
                end
            end
        end else if (v !== 1'b0) begin
            nbad++;
            $display("FAIL valid_unknown dut%0d: rx_valid=%b, required 0", k, v);
        end else if (q[k].size() > 0 && q[k][0].due == cur) begin
            nbad++;
            e = q[k].pop_front();
            last[k] = e.data;
            $display("FAIL missed_capture dut%0d: rx_valid=0 at edge %0d, required 1 with data %h", k, cur, e.data);
        end else if (d !== last[k]) begin
            nbad++;
            $display("FAIL hold_data dut%0d: rx_data=%h, required %h", k, d, last[k]);
        end
    endtask

    // Monitor: compare both instances away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check(0, if2.rx_valid, if2.rx_data);
            check(1, if3.rx_valid, if3.rx_data);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        last[0] = '0;
        last[1] = '0;
        en_seen = 1'b0;
    endtask

    task automatic check_async_clear();
        #1;
        nvec++;
        if (if2.rx_data !== '0 || if2.rx_valid !== 1'b0 || if3.rx_data !== '0 || if3.rx_valid !== 1'b0) begin
            nbad++;
            $display("FAIL async_clear: rx_data=%h/%h rx_valid=%b/%b, required 00/00 0/0",
                     if2.rx_data, if3.rx_data, if2.rx_valid, if3.rx_valid);
        end
    endtask

    // Watchdog: the run is bounded regardless of DUT behaviour.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last[0] = '0;
        last[1] = '0;
        rst_n   = 1'b0;
        en      = 1'b1;
        tx      = 8'hAF;

        // Reset held with EN high and a live bus.
        step(4);
        tx = 8'h99;
        step(1);
        rst_n = 1'b1;
        step(8);

        // Two separate EN rises, each one capture.
        en = 1'b0;
        step(3);
        tx = 8'hFF;
        en = 1'b1;
        step(5);
        en = 1'b0;
        step(3);
        tx = 8'h98;
        en = 1'b1;
        step(5);

        // Bus changes while EN is low are ignored.
        en = 1'b0;
        step(1);
        tx = 8'hCC;
        step(4);
        tx = 8'h0F;
        en = 1'b1;
        step(5);

        // EN held high for 20 cycles with a mid-way bus change.
        en = 1'b0;
        step(3);
        tx = 8'h11;
        en = 1'b1;
        step(10);
        tx = 8'h22;
        step(10);
        en = 1'b0;
        step(3);

        // Reset between EN rise and capture discards the pending load.
        tx = 8'h55;
        en = 1'b1;
        step(1);
        assert_reset();
        check_async_clear();
        step(3);
        en = 1'b0;
        rst_n = 1'b1;
        step(3);

        // Reset during the rx_valid cycle clears outputs immediately.
        tx = 8'h3C;
        en = 1'b1;
        step(3);
        assert_reset();
        check_async_clear();
        step(2);
        en = 1'b0;
        rst_n = 1'b1;
        step(3);

        // Randomized traffic honouring the source contract.
        for (int i = 0; i < 80; i++) begin
            int hi;
            int lo;
            tx = W'($urandom);
            en = 1'b1;
            step(4);
            hi = int'($urandom_range(0, 6));
            repeat (hi) begin
                if ($urandom_range(0, 1) == 1) tx = W'($urandom);
                step(1);
            end
            en = 1'b0;
            lo = int'($urandom_range(2, 6));
            repeat (lo) begin
                tx = W'($urandom);
                step(1);
            end
            if ($urandom_range(0, 9) == 0) begin
                assert_reset();
                check_async_clear();
                step(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
                step(2);
            end
        end

        en = 1'b0;
        step(8);

        // Every queued capture must have been observed.
        for (int k = 0; k < 2; k++) begin
            nvec++;
            if (q[k].size() != 0) begin
                nbad++;
                $display("FAIL pending_captures dut%0d: %0d outstanding, required 0", k, q[k].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
